// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 6
) ();
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;

    modport slave  (input  in_valid, in_data, output in_ready, we, waddr, wdata);
    modport master (output in_valid, in_data, input  in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream -> 32-bit words,
// core held in reset until the complete image has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // One bit wider than the count so the depth check never truncates.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_count;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [31:0]           r_asm;
    logic [31:0]           w_asm_nxt;
    logic                  r_in_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;
    logic                  w_accept;
    logic [15:0]           w_len;
    logic                  w_last_word;
    logic [1:0]            w_lane;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_len       = {r_count[15:8], bus.in_data};
    assign w_last_word = (16'(r_word_idx) == (r_count - 16'd1));
    assign w_lane      = BIG_ENDIAN ? (2'd3 - r_byte_idx) : r_byte_idx;

    // Merge the incoming byte into its lane of the word being assembled.
    always_comb begin
        w_asm_nxt = r_asm;
        case (w_lane)
            2'd0:    w_asm_nxt[7:0]   = bus.in_data;
            2'd1:    w_asm_nxt[15:8]  = bus.in_data;
            2'd2:    w_asm_nxt[23:16] = bus.in_data;
            2'd3:    w_asm_nxt[31:24] = bus.in_data;
            default: w_asm_nxt        = r_asm;
        endcase
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_state_nxt = S_LEN_HI;
                else       w_state_nxt = r_state;
            end
            S_LEN_HI: begin
                if (w_accept) w_state_nxt = S_LEN_LO;
                else          w_state_nxt = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (!w_accept)                    w_state_nxt = S_LEN_LO;
                else if (w_len == 16'd0)          w_state_nxt = S_DONE;
                else if ({1'b0, w_len} > DEPTH)   w_state_nxt = S_ERR;
                else                              w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3)) w_state_nxt = S_WRITE;
                else                                  w_state_nxt = S_DATA;
            end
            S_WRITE: begin
                if (w_last_word) w_state_nxt = S_DONE;
                else             w_state_nxt = S_DATA;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and outputs registered together so every output is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            r_word_idx  <= '0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 32'd0;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                           (w_state_nxt == S_DATA);
            r_we        <= (w_state_nxt == S_WRITE);
            r_cpu_reset <= (w_state_nxt != S_DONE);
            r_done      <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERR);
            case (r_state)
                S_LEN_HI: begin
                    if (w_accept) r_count[15:8] <= bus.in_data;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= bus.in_data;
                        r_word_idx   <= '0;
                        r_byte_idx   <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_asm      <= w_asm_nxt;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wdata <= w_asm_nxt;
                            r_waddr <= r_word_idx;
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_last_word) r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign error        = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench: one big-endian and one little-endian loader
// share the same stream and are checked against a word-level reference model.
module tb_imem_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'd0;
    logic       cpu_reset_be, done_be, error_be;
    logic       cpu_reset_le, done_le, error_le;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_we_cyc = 0;
    int ready_in_we = 0;
    int          got_be_a[$];
    logic [31:0] got_be_d[$];
    int          got_le_a[$];
    logic [31:0] got_le_d[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus_be ();
    imem_loader_if #(.ADDR_WIDTH(AW)) bus_le ();

    assign bus_be.in_valid = in_valid;
    assign bus_be.in_data  = in_data;
    assign bus_le.in_valid = in_valid;
    assign bus_le.in_data  = in_data;

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_be.slave),
        .cpu_reset(cpu_reset_be), .done(done_be), .error(error_be));

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_le.slave),
        .cpu_reset(cpu_reset_le), .done(done_le), .error(error_le));

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: one sample per we pulse, taken mid-cycle.
    always @(negedge clk) begin
        if (bus_be.we === 1'b1) begin
            got_be_a.push_back(int'(bus_be.waddr));
            got_be_d.push_back(bus_be.wdata);
            last_we_cyc = cyc;
            if (bus_be.in_ready !== 1'b0) ready_in_we++;
        end
        if (bus_le.we === 1'b1) begin
            got_le_a.push_back(int'(bus_le.waddr));
            got_le_d.push_back(bus_le.wdata);
            if (bus_le.in_ready !== 1'b0) ready_in_we++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: header gives word count; outcome 1 = done, 2 = error.
    function automatic void model(input logic [7:0] b[$], input bit be,
                                  output logic [31:0] words[$], output int outcome);
        int count;
        logic [31:0] w;
        count = int'(b[0]) * 256 + int'(b[1]);
        words = {};
        if (count > DEPTH) begin
            outcome = 2;
        end else begin
            outcome = 1;
            for (int i = 0; i < count; i++) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++)
                    w |= 32'(b[2 + 4 * i + j]) << (be ? 8 * (3 - j) : 8 * j);
                words.push_back(w);
            end
        end
    endfunction

    task automatic clear_logs();
        got_be_a = {}; got_be_d = {}; got_le_a = {}; got_le_d = {};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},        32'(bus_be.we),       32'd0);
        check({tag, "_waddr"},     32'(bus_be.waddr),    32'd0);
        check({tag, "_wdata"},     bus_be.wdata,         32'd0);
        check({tag, "_in_ready"},  32'(bus_be.in_ready), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset_be),    32'd1);
        check({tag, "_done"},      32'(done_be),         32'd0);
        check({tag, "_error"},     32'(error_be),        32'd0);
        check({tag, "_le_wdata"},  bus_le.wdata,         32'd0);
        check({tag, "_le_cpu_rst"}, 32'(cpu_reset_le),   32'd1);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_ready"}, 32'(bus_be.in_ready), 32'd1);
        check({tag, "_start_cpurst"}, 32'(cpu_reset_be),   32'd1);
    endtask

    task automatic send(input logic [7:0] b[$], input bit gaps);
        int t;
        foreach (b[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            if (gaps) start = ($urandom_range(0, 7) == 0);
            t = 0;
            while (bus_be.in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("ready_timeout", 32'(t), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic run_load(input string tag, input logic [7:0] b[$], input bit gaps);
        logic [31:0] exp_be[$];
        logic [31:0] exp_le[$];
        int outcome;
        int t;
        int done_cyc;
        model(b, 1'b1, exp_be, outcome);
        model(b, 1'b0, exp_le, outcome);
        clear_logs();
        ready_in_we = 0;
        pulse_start(tag);
        send(b, gaps);
        t = 0;
        while (!(done_be === 1'b1 || error_be === 1'b1) && t < 400) begin
            @(negedge clk);
            t++;
        end
        done_cyc = cyc;
        check({tag, "_settle"},    32'(t), (exp_be.size() > 0) ? 32'd1 : 32'd0);
        check({tag, "_done"},      32'(done_be),      (outcome == 1) ? 32'd1 : 32'd0);
        check({tag, "_error"},     32'(error_be),     (outcome == 2) ? 32'd1 : 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset_be), (outcome == 2) ? 32'd1 : 32'd0);
        check({tag, "_in_ready"},  32'(bus_be.in_ready), 32'd0);
        check({tag, "_le_done"},   32'(done_le),      (outcome == 1) ? 32'd1 : 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"},    32'(got_be_d.size()), 32'(exp_be.size()));
        check({tag, "_le_nwrites"}, 32'(got_le_d.size()), 32'(exp_le.size()));
        check({tag, "_ready_in_we"}, 32'(ready_in_we), 32'd0);
        if (exp_be.size() > 0 && got_be_d.size() == exp_be.size()) begin
            check({tag, "_done_edge"}, 32'(done_cyc), 32'(last_we_cyc + 1));
            foreach (exp_be[i]) begin
                check({tag, "_addr"},  32'(got_be_a[i]), 32'(i));
                check({tag, "_data"},  got_be_d[i], exp_be[i]);
            end
        end
        if (exp_le.size() > 0 && got_le_d.size() == exp_le.size()) begin
            foreach (exp_le[i]) begin
                check({tag, "_le_addr"}, 32'(got_le_a[i]), 32'(i));
                check({tag, "_le_data"}, got_le_d[i], exp_le[i]);
            end
        end
    endtask

    function automatic void make_stream(input int count, input int nwords, output logic [7:0] q[$]);
        q = {};
        q.push_back(8'(count >> 8));
        q.push_back(8'(count));
        for (int i = 0; i < nwords * 4; i++) q.push_back(8'($urandom_range(0, 255)));
    endfunction

    initial begin
        logic [7:0] q[$];
        logic [31:0] exp_w[$];
        int outcome;
        int n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        q = {8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
        run_load("two_word", q, 1'b0);
        check("two_word_w0_const", got_be_d.size() > 0 ? got_be_d[0] : 32'hX, 32'h8C010004);
        check("two_word_w1_const", got_be_d.size() > 1 ? got_be_d[1] : 32'hX, 32'h00221820);

        q = {8'h00, 8'h00};
        run_load("zero", q, 1'b0);

        q = {8'h00, 8'h41};
        run_load("overflow", q, 1'b0);

        q = {8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
        run_load("gapped", q, 1'b1);

        q = {8'h00, 8'h01, 8'h04, 8'h00, 8'h01, 8'h8C};
        run_load("little", q, 1'b0);
        check("little_le_const", got_le_d.size() > 0 ? got_le_d[0] : 32'hX, 32'h8C010004);

        // Abort after six data bytes of a three-word image.
        make_stream(3, 3, q);
        model(q, 1'b1, exp_w, outcome);
        clear_logs();
        pulse_start("abort");
        send(q[0:7], 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        repeat (4) @(negedge clk);
        check("abort_nwrites", 32'(got_be_d.size()), 32'd1);
        if (got_be_d.size() > 0) check("abort_w0", got_be_d[0], exp_w[0]);
        check("abort_held", 32'(cpu_reset_be), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        run_load("after_reset", q, 1'b1);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, DEPTH);
            make_stream(n, n, q);
            run_load("random", q, 1'b1);
        end
        make_stream(DEPTH, DEPTH, q);
        run_load("full_depth", q, 1'b0);
        make_stream(DEPTH + 1, 0, q);
        run_load("depth_plus1", q, 1'b0);
        make_stream(16'h0100, 0, q);
        run_load("no_truncate", q, 1'b0);
        make_stream(16'hFFFF, 0, q);
        run_load("max_count", q, 1'b1);
        make_stream(1, 1, q);
        run_load("reload_after_err", q, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
